ascon_in_serializer: RTL
========================

ASCON_IN_SERIALIZER -- requirements
Module: ascon_in_serializer

Interface
REQ-001 SHALL have parameters: K, default 128, key width; L, default 40, associated-data width; Y, default 96, plaintext width; START_LEN, default 5, start-pulse length in cycles.
REQ-002 SHALL derive a localparam MAX = max(K, L, Y), the shift-cycle count.
REQ-003 SHALL use one clock; reset is asynchronous and active-high. The ports are: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-004 SHALL have the following ports:
- load_valid  in  1  host offers a job.
- load_ready  out  1  serializer accepts a job.
- mode  in  1  0 = encrypt, 1 = decrypt.
- key  in  K.
- nonce  in  128.
- ad  in  L.
- pt  in  Y.
- rnd  in  36  external randomness.
- enc_ready  in  1  core encryption-done.
- dec_ready  in  1  core decryption-done.
- keyxSI, noncexSI, associated_dataxSI, plain_textxSI  out  5 each  bit 0 is data, bits 4:1 are mask.
- r_64xSI  out  14.
- r_128xSI  out  3.
- r_ptxSI  out  3.
- encryption_startxSI  out  1.
- decryption_startxSI  out  1.
- busy  out  1.

Function
REQ-005 SHALL implement the states IDLE, SHIFT, START and WAIT.
REQ-006 SHALL assert load_ready only in IDLE; a job is accepted on the clk edge where load_valid && load_ready.
- On acceptance, key/nonce/ad/pt/mode are latched into internal registers.
- The counter is cleared.
- The state goes to SHIFT.
REQ-007 SHALL spend exactly MAX cycles in SHIFT; on cycle i (0..MAX-1) it drives:
- keyxSI[0] = key[K-1-i]
- noncexSI[0] = nonce[127-i]
- associated_dataxSI[0] = ad[L-1-i]
- plain_textxSI[0] = pt[Y-1-i]
REQ-008 SHALL drive a data bit 0 on any lane whose index i is at or beyond that lane's width (no X propagation).
REQ-009 SHALL refresh all 36 random bits every cycle outside IDLE, in this order (MSB first): {r_128xSI, r_ptxSI, r_64xSI, keyxSI[4:1], associated_dataxSI[4:1], plain_textxSI[4:1], noncexSI[4:1]}.
REQ-010 SHALL, after the last SHIFT cycle, enter START and hold it for START_LEN cycles.
- During START, exactly one of encryption_startxSI (mode=0) or decryption_startxSI (mode=1) is high.
- During START, data bits hold 0.
REQ-011 SHALL enter WAIT after START and stay there until the ready input matching the latched mode is high; it then returns to IDLE on the next edge.
REQ-012 SHALL ignore the non-matching ready input, and ignore load_valid outside IDLE.
REQ-013 SHALL drive busy = (state != IDLE).
REQ-014 SHALL register all serial outputs so they change only on clk rising edges. Latency is 1 cycle from acceptance to the first data bit. A job takes MAX+START_LEN cycles to the start de-assert.
REQ-015 SHALL count with a counter of width clog2(MAX+START_LEN)+1; the counter never wraps within a job.

Reset
REQ-016 SHALL, while rst is high, asynchronously force:
- state = IDLE
- counter = 0
- all serial, random and start outputs = 0
- busy = 0
- load_ready = 0
REQ-017 SHALL assert load_ready from the first clk edge after rst falls.
REQ-018 SHALL abandon any job on rst mid-operation with no start pulse; a new job is accepted normally afterwards.

Configuration
REQ-019 SHALL, with ASCON_SER_LFSR_EN defined, source the 36 random bits from an internal 64-bit maximal-length LFSR. The LFSR has a nonzero reset seed, advances every cycle outside IDLE, and the rnd port is ignored.
REQ-020 SHALL, without ASCON_SER_LFSR_EN, register the rnd port directly into the random outputs.

Structure
REQ-021 SHALL place the state enum, RND_W = 36, the field offsets of the random vector and a max3 function in shared package ascon_pkg.
REQ-022 SHALL implement the LFSR as sub-module ascon_lfsr, instantiated only under ASCON_SER_LFSR_EN.

Verification
REQ-023 Scenario 1: reset, then encrypt with the following inputs:
- key = 5362006eff0b33bc8bb9950abdb242fc
- nonce = 1ccfafbc6dc738283ca9fe21ce0fccaa
- ad = 4153434f4e
- pt = 48656c6c6f20576f726c6421
Required response:
- Bit 0 of key/nonce/ad/pt is 0/0/0/0 on cycle 0 and 1/0/1/1 on cycle 1.
- There are 128 SHIFT cycles.
- encryption_startxSI is high for 5 cycles.
REQ-024 Scenario 2: the same vectors with L=40 and Y=96 -> associated_dataxSI[0] = 0 for i ≥ 40 and plain_textxSI[0] = 0 for i ≥ 96.
REQ-025 Scenario 3: mode=1 -> decryption_startxSI pulses for 5 cycles; encryption_startxSI stays 0; enc_ready asserted during WAIT is ignored; dec_ready returns the block to IDLE in 1 cycle.
REQ-026 Scenario 4: rst asserted at SHIFT cycle 60 -> outputs are 0 immediately with no start pulse; a following job serializes from i=0.
REQ-027 Scenario 5: load_valid held high through a job -> exactly one acceptance per IDLE visit; load_ready stays 0 while busy.
REQ-028 Scenario 6: with the macro undefined, rnd = 0x9_ABCD_1234 -> the random outputs equal that value one cycle later; with the macro defined, the random outputs are nonzero and change every cycle.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon input serializer: FSM states,
// random-vector layout and a small elaboration-time helper.
package ascon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } ser_state_e;

    localparam int RND_W  = 36;
    localparam int MASK_W = 4;
    localparam int R64_W  = 14;
    localparam int RPT_W  = 3;
    localparam int R128_W = 3;

    // Bit offsets inside the 36-bit random vector, LSB field first
    localparam int NONCE_M_OFF = 0;
    localparam int PT_M_OFF    = 4;
    localparam int AD_M_OFF    = 8;
    localparam int KEY_M_OFF   = 12;
    localparam int R64_OFF     = 16;
    localparam int RPT_OFF     = 30;
    localparam int R128_OFF    = 33;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/ascon_lfsr.sv
// 64-bit maximal-length Fibonacci LFSR (x^64 + x^63 + x^61 + x^60 + 1) that
// supplies mask randomness when ASCON_SER_LFSR_EN is defined.
module ascon_lfsr
    import ascon_pkg::*;
#(
    parameter logic [63:0] SEED = 64'hACE1_5EED_C0DE_F00D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [RND_W-1:0] value
);

    logic [63:0] state_r;
    logic        fb_s;

    assign fb_s  = state_r[63] ^ state_r[62] ^ state_r[60] ^ state_r[59];
    assign value = state_r[RND_W-1:0];

    // Advance the sequence only while the serializer is working
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SEED;
        end else if (en) begin
            state_r <= {state_r[62:0], fb_s};
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: rtl/ascon_in_serializer.sv
// Bit-serial front end for a masked Ascon core: latches a job, shifts key/nonce/AD/PT
// MSB first with fresh mask bits, then pulses the core start. ASCON_SER_LFSR_EN selects internal randomness.
module ascon_in_serializer
    import ascon_pkg::*;
#(
    parameter int K         = 128,
    parameter int L         = 40,
    parameter int Y         = 96,
    parameter int START_LEN = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         mode,
    input  logic [K-1:0] key,
    input  logic [127:0] nonce,
    input  logic [L-1:0] ad,
    input  logic [Y-1:0] pt,
    input  logic [35:0]  rnd,
    input  logic         enc_ready,
    input  logic         dec_ready,
    output logic [4:0]   keyxSI,
    output logic [4:0]   noncexSI,
    output logic [4:0]   associated_dataxSI,
    output logic [4:0]   plain_textxSI,
    output logic [13:0]  r_64xSI,
    output logic [2:0]   r_128xSI,
    output logic [2:0]   r_ptxSI,
    output logic         encryption_startxSI,
    output logic         decryption_startxSI,
    output logic         busy
);

    localparam int MAX   = max3(K, L, Y);
    localparam int CNT_W = $clog2(MAX + START_LEN) + 1;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(MAX - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(MAX + START_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    ser_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             mode_r, mode_s;
    logic [K-1:0]     key_r, key_s;
    logic [127:0]     nonce_r, nonce_s;
    logic [L-1:0]     ad_r, ad_s;
    logic [Y-1:0]     pt_r, pt_s;
    logic [3:0]       bits_r, bits_s;
    logic             enc_start_r, dec_start_r;
    logic             load_ready_r, busy_r;
    logic [RND_W-1:0] rnd_r, rnd_src_s;
    logic             rnd_en_s;

    // Mask bits refresh on every edge that lands outside IDLE
    assign rnd_en_s = (state_s != IDLE);

`ifdef ASCON_SER_LFSR_EN
    logic rnd_unused_s;
    assign rnd_unused_s = ^rnd;

    ascon_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (rnd_en_s),
        .value (rnd_src_s)
    );
`else
    assign rnd_src_s = rnd;
`endif

    // Next-state logic; lanes are left-shifting copies so exhausted lanes feed zeros
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        mode_s  = mode_r;
        key_s   = key_r;
        nonce_s = nonce_r;
        ad_s    = ad_r;
        pt_s    = pt_r;
        bits_s  = 4'b0000;
        case (state_r)
            IDLE: begin
                if (load_valid && load_ready_r) begin
                    state_s = SHIFT;
                    cnt_s   = {CNT_W{1'b0}};
                    mode_s  = mode;
                    bits_s  = {key[K-1], nonce[127], ad[L-1], pt[Y-1]};
                    key_s   = {key[K-2:0], 1'b0};
                    nonce_s = {nonce[126:0], 1'b0};
                    ad_s    = {ad[L-2:0], 1'b0};
                    pt_s    = {pt[Y-2:0], 1'b0};
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                cnt_s = cnt_r + CNT_ONE;
                if (cnt_r == SHIFT_LAST) begin
                    state_s = START;
                end else begin
                    bits_s  = {key_r[K-1], nonce_r[127], ad_r[L-1], pt_r[Y-1]};
                    key_s   = {key_r[K-2:0], 1'b0};
                    nonce_s = {nonce_r[126:0], 1'b0};
                    ad_s    = {ad_r[L-2:0], 1'b0};
                    pt_s    = {pt_r[Y-2:0], 1'b0};
                end
            end
            START: begin
                cnt_s = cnt_r + CNT_ONE;
                if (cnt_r == START_LAST) begin
                    state_s = WAIT;
                end else begin
                    state_s = START;
                end
            end
            WAIT: begin
                if (mode_r ? dec_ready : enc_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, job registers and every output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            mode_r       <= 1'b0;
            key_r        <= {K{1'b0}};
            nonce_r      <= 128'd0;
            ad_r         <= {L{1'b0}};
            pt_r         <= {Y{1'b0}};
            bits_r       <= 4'b0000;
            enc_start_r  <= 1'b0;
            dec_start_r  <= 1'b0;
            load_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            rnd_r        <= {RND_W{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            mode_r       <= mode_s;
            key_r        <= key_s;
            nonce_r      <= nonce_s;
            ad_r         <= ad_s;
            pt_r         <= pt_s;
            bits_r       <= bits_s;
            enc_start_r  <= (state_s == START) && !mode_s;
            dec_start_r  <= (state_s == START) && mode_s;
            load_ready_r <= (state_s == IDLE);
            busy_r       <= (state_s != IDLE);
            if (rnd_en_s) begin
                rnd_r <= rnd_src_s;
            end else begin
                rnd_r <= rnd_r;
            end
        end
    end

    assign load_ready          = load_ready_r;
    assign busy                = busy_r;
    assign encryption_startxSI = enc_start_r;
    assign decryption_startxSI = dec_start_r;
    assign keyxSI              = {rnd_r[KEY_M_OFF +: MASK_W], bits_r[3]};
    assign noncexSI            = {rnd_r[NONCE_M_OFF +: MASK_W], bits_r[2]};
    assign associated_dataxSI  = {rnd_r[AD_M_OFF +: MASK_W], bits_r[1]};
    assign plain_textxSI       = {rnd_r[PT_M_OFF +: MASK_W], bits_r[0]};
    assign r_64xSI             = rnd_r[R64_OFF +: R64_W];
    assign r_ptxSI             = rnd_r[RPT_OFF +: RPT_W];
    assign r_128xSI            = rnd_r[R128_OFF +: R128_W];

endmodule
